// File: rtl/quant_pkg.sv
// Shared types for the requant output path: byte type and the packed word
// carried from the packer through its output FIFO.
package quant_pkg;

    localparam int BYTE_W   = 8;
    localparam int PK_LANES = 4;

    typedef logic [BYTE_W-1:0] byte_t;

    // Word width follows PK_LANES; requant_pack's LANES must match it.
    typedef struct packed {
        byte_t [PK_LANES-1:0] data;
        logic  [PK_LANES-1:0] strb;
        logic                 last;
    } pack_word_t;

endpackage

// File: rtl/pack_fifo.sv
// First-word-fall-through FIFO of packed words; head entry is visible on
// rdata whenever empty=0.
module pack_fifo
    import quant_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  pack_word_t               wdata,
    input  logic                     pop,
    output pack_word_t               rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    pack_word_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/requant_pack.sv
// Packs requantized bytes into little-endian words with lane strobes, queues
// them for the memory writer, and flags bytes lost to back-pressure.
module requant_pack
    import quant_pkg::*;
#(
    parameter int LANES = PK_LANES,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    input  logic               in_last,
    output logic               in_ready,
    output logic               out_valid,
    output logic [8*LANES-1:0] out_data,
    output logic [LANES-1:0]   out_strb,
    output logic               out_last,
    input  logic               out_ready,
    input  logic               err_clr,
    output logic               drop_err
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);

    logic [LW-1:0]         lane_cnt;
    byte_t [LANES-1:0]     asm_data;
    logic  [LANES-1:0]     asm_strb;
    logic                  accept, word_done, push;
    pack_word_t            push_word, head;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_full, fifo_empty;

    // Ready depends only on registered occupancy, never on out_ready.
    assign in_ready  = rst && (fifo_count < DEPTH_C);
    assign accept    = in_valid && in_ready;
    assign word_done = (lane_cnt == LAST_LANE) || in_last;
    assign push      = accept && word_done && !fifo_full;

    // Word being pushed = assembly register with the incoming byte merged in.
    always_comb begin
        push_word                = '0;
        push_word.data           = asm_data;
        push_word.strb           = asm_strb;
        push_word.data[lane_cnt] = in_data;
        push_word.strb[lane_cnt] = 1'b1;
        push_word.last           = in_last;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            lane_cnt <= '0;
            asm_data <= '0;
            asm_strb <= '0;
            drop_err <= 1'b0;
        end else begin
            if (accept) begin
                if (word_done) begin
                    lane_cnt <= '0;
                    asm_data <= '0;
                    asm_strb <= '0;
                end else begin
                    asm_data[lane_cnt] <= in_data;
                    asm_strb[lane_cnt] <= 1'b1;
                    lane_cnt           <= lane_cnt + 1'b1;
                end
            end
            if (in_valid && !in_ready)
                drop_err <= 1'b1;
            else if (err_clr)
                drop_err <= 1'b0;
        end
    end

    pack_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (push_word),
        .pop   (out_valid && out_ready),
        .rdata (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Zero the head fields when empty so storage contents never leak out.
    assign out_valid = !fifo_empty;
    assign out_data  = fifo_empty ? '0 : head.data;
    assign out_strb  = fifo_empty ? '0 : head.strb;
    assign out_last  = fifo_empty ? 1'b0 : head.last;

endmodule

// File: tb/tb_requant_pack.sv
// Scoreboard bench for requant_pack: stimulus queues expected words, a
// negedge monitor pops and compares every handshaken output word.
module tb_requant_pack;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [3:0]  out_strb;
    logic        out_last;
    logic        out_ready = 1'b0;
    logic        err_clr = 1'b0;
    logic        drop_err;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  s;
        logic        l;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;

    requant_pack #(.LANES(4), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_strb  (out_strb),
        .out_last  (out_last),
        .out_ready (out_ready),
        .err_clr   (err_clr),
        .drop_err  (drop_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        in_valid = 1'b1;
        in_data  = b;
        in_last  = last;
        cyc();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_word(input logic [31:0] d, input logic [3:0] s, input logic l);
        exp_t e;
        e.d = d;
        e.s = s;
        e.l = l;
        sb.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 50; i++) begin
            if (sb.size() == 0) break;
            cyc();
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    // Monitor: every accepted output word must match the scoreboard head.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_word: got %h with nothing expected", out_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("word_data", 64'(out_data), 64'(e.d));
                chk("word_strb", 64'(out_strb), 64'(e.s));
                chk("word_last", 64'(out_last), 64'(e.l));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (3) cyc();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);
        chk("rst_out_strb",  64'(out_strb),  64'd0);
        chk("rst_out_last",  64'(out_last),  64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd0);
        chk("rst_drop_err",  64'(drop_err),  64'd0);
        rst = 1'b1;
        #1;
        chk("ready_after_rst", 64'(in_ready), 64'd1);

        // Full word, out_valid for exactly one cycle
        out_ready = 1'b1;
        expect_word(32'h44332211, 4'hF, 1'b1);
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        send(8'h44, 1'b1);
        chk("full_valid_hi", 64'(out_valid), 64'd1);
        cyc();
        chk("full_valid_lo", 64'(out_valid), 64'd0);

        // Partial flush, then a 1-byte row restarting at lane 0
        expect_word(32'h0000BBAA, 4'h3, 1'b1);
        expect_word(32'h000000C1, 4'h1, 1'b1);
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b1);
        send(8'hC1, 1'b1);
        drain();

        // Back-pressure: 16 bytes fill all 4 entries
        out_ready = 1'b0;
        expect_word(32'h03020100, 4'hF, 1'b0);
        expect_word(32'h07060504, 4'hF, 1'b0);
        expect_word(32'h0B0A0908, 4'hF, 1'b0);
        expect_word(32'h0F0E0D0C, 4'hF, 1'b0);
        for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
        chk("bp_in_ready",  64'(in_ready),  64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        chk("bp_no_drop",   64'(drop_err),  64'd0);

        // Drop while full, clear, and set-beats-clear
        send(8'h55, 1'b0);
        chk("drop_set",      64'(drop_err), 64'd1);
        chk("drop_ready",    64'(in_ready), 64'd0);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        chk("drop_clr", 64'(drop_err), 64'd0);
        in_valid = 1'b1;
        in_data  = 8'h66;
        err_clr  = 1'b1;
        cyc();
        in_valid = 1'b0;
        err_clr  = 1'b0;
        chk("drop_set_wins", 64'(drop_err), 64'd1);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        chk("drop_clr2", 64'(drop_err), 64'd0);
        out_ready = 1'b1;
        drain();

        // Simultaneous push and pop at count=2
        out_ready = 1'b0;
        expect_word(32'h23222120, 4'hF, 1'b0);
        expect_word(32'h27262524, 4'hF, 1'b0);
        expect_word(32'h2B2A2928, 4'hF, 1'b0);
        for (int i = 0; i < 11; i++) send(8'(8'h20 + i), 1'b0);
        chk("simul_pre_count", 64'(dut.u_fifo.count), 64'd2);
        out_ready = 1'b1;
        send(8'h2B, 1'b0);
        chk("simul_count", 64'(dut.u_fifo.count), 64'd2);
        chk("simul_ready", 64'(in_ready), 64'd1);
        drain();

        // Mid-row reset discards the partial word
        send(8'hE1, 1'b0);
        send(8'hE2, 1'b0);
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        chk("midrst_valid", 64'(out_valid), 64'd0);
        expect_word(32'h04030201, 4'hF, 1'b1);
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        send(8'h04, 1'b1);
        drain();
        repeat (3) cyc();
        chk("final_idle", 64'(out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/requant_pack.md
Name: requant_pack

Overview:
- Sits directly downstream of the requant stage.
- Collects its 8-bit saturated outputs into 32-bit little-endian words with per-byte strobes.
- Buffers the words in a small first-word-fall-through (FWFT) FIFO and hands them to the output memory writer over a valid/ready handshake.
- Flags any byte lost to back-pressure, because the requant pipeline cannot stall mid-flight.

Parameters:
- LANES, 4, bytes per output word; out_data width = 8*LANES.
- DEPTH, 4, output FIFO depth in words; power of two, >= 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- in_valid  in  1  byte present (the requant output-valid, i.e. the delayed en).
- in_data  in  8  requantized byte.
- in_last  in  1  final byte of the tensor row; flushes a partial word.
- in_ready  out  1  block can accept a byte this cycle.
- out_valid  out  1  head word valid.
- out_data  out  8*LANES  packed word, lane i at bits [8i+7:8i].
- out_strb  out  LANES  lane-valid mask.
- out_last  out  1  word closes a row.
- out_ready  in  1  consumer accepts the head word.
- err_clr  in  1  clears drop_err.
- drop_err  out  1  sticky: a byte was offered while in_ready=0.

Behaviour:
- Reset (rst=0 at a clk edge):
  - lane_cnt, assembly register, strobe mask, FIFO pointers/count and drop_err all go to 0.
  - out_valid=0, out_data=0, out_strb=0, out_last=0.
  - in_ready=0 while rst=0; in_ready=1 on the first cycle after release.
  - Reset mid-row discards the partial word and all FIFO contents. Nothing is emitted.
- Byte accept:
  - A byte is accepted when in_valid && in_ready.
  - The accepted byte is written into lane lane_cnt and sets strobe bit lane_cnt.
  - lane_cnt increments.
- Word complete: when the accepted byte fills lane LANES-1, or in_last=1:
  - Push {data, strb, last=in_last} to the FIFO on the same edge.
  - Clear the assembly register, strobe and lane_cnt to 0.
  - Unused lanes of a flushed partial word are 0 with strb=0.
- in_ready = (fifo_count < DEPTH), driven from registered state only. It does not look ahead on a same-cycle pop; no combinational path from out_ready to in_ready.
- FIFO:
  - FWFT: out_valid = (count != 0); out_data/strb/last show the head entry.
  - Pop on out_valid && out_ready.
  - Simultaneous push and pop: count unchanged, both pointers advance. Legal at count=DEPTH only if the push condition was already permitted (it is not, since in_ready=0 at full).
  - Pointers wrap modulo DEPTH.
- Latency: a word completed at edge N shows out_valid=1 after edge N, provided the FIFO was empty. Throughput is one word per cycle.
- out_* hold stable while out_valid && !out_ready.
- drop_err:
  - Set on in_valid && !in_ready (the byte is discarded; lane_cnt unchanged).
  - Cleared by err_clr. If set and clear occur together, set wins.
- in_last with no byte (in_valid=0) is ignored.
- in_last on lane 0 produces a 1-byte word with strb=4'b0001.

Decomposition:
- Package quant_pkg:
  - BYTE_W=8.
  - typedef byte_t (logic [7:0]).
  - typedef pack_word_t struct {data, strb, last}, sized from LANES.
- Sub-module pack_fifo: parameterized FWFT synchronous FIFO of pack_word_t with push/pop/count/full/empty, same clock and reset.
- Packing logic and the error flag live in requant_pack.

Test Plan:
- Full word: bytes 0x11,0x22,0x33,0x44, with in_last on 0x44, out_ready=1 -> one word, out_data=0x44332211, strb=0xF, last=1, out_valid high for exactly 1 cycle.
- Partial flush: bytes 0xAA,0xBB with in_last on 0xBB -> out_data=0x0000BBAA, strb=0x3, last=1; next row restarts at lane 0.
- Back-pressure:
  - out_ready=0, stream 16 bytes -> in_ready drops to 0 after the 4th word is pushed; FIFO holds 4 words.
  - Then raise out_ready -> words are drained in order 0x03020100 .. 0x0F0E0D0C.
- Drop: with the FIFO full, assert in_valid with 0x55 -> drop_err=1, no FIFO change. Assert err_clr -> drop_err=0 on the next cycle.
- Simultaneous push/pop: FIFO count=2 and out_ready=1 while a word completes -> count stays 2, order preserved.
- Mid-row reset: 2 bytes accepted, then rst=0 for 1 cycle, then bytes 0x01..0x04 -> single output word 0x04030201, no residue from the earlier bytes.
